// File: rtl/dio_mem_bridge_pkg.sv
// dio_mem_bridge_pkg: shared FSM states, FIFO entry field widths and lane helper
package dio_mem_bridge_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam int BE_W  = 4;
  localparam int DAT_W = 32;
  function automatic logic [DAT_W-1:0] lane_mask(input logic [BE_W-1:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/dio_word_fifo.sv
// dio_word_fifo: synchronous first-word fall-through FIFO of packed word writes
//   push/din write an entry (ignored when full unless popped in the same cycle),
//   pop retires the head shown on dout; full/empty report occupancy.
module dio_word_fifo #(
  parameter int W  = 58,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt[AW];
  assign do_pop = pop & ~empty;
  // a pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/dio_mem_bridge.sv
// dio_mem_bridge: packs data_io byte writes into 32-bit bus writes and serves uploads from a one-word read cache
//   dio_*: byte port from data_io (no backpressure); downloading/uploading: transfer levels
//   wb_*: 32-bit bus master; busy: work outstanding; overflow: sticky word-drop flag
module dio_mem_bridge
  import dio_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dio_wr,
  input  logic [ADDR_WIDTH-1:0] dio_a,
  input  logic [3:0]            dio_sel,
  input  logic [31:0]           dio_dout,
  output logic [7:0]            dio_din,
  input  logic                  downloading,
  input  logic                  uploading,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-3:0] wb_adr,
  output logic [3:0]            wb_sel,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack,
  output logic                  busy,
  output logic                  overflow
);
  localparam int WA = ADDR_WIDTH - 2;
  localparam int EW = WA + BE_W + DAT_W;
  logic [WA-1:0] word, acc_adr, rd_adr, cache_adr, head_adr;
  logic [31:0] acc_data, cache_data, head_dat, new_data;
  logic [3:0] acc_be, head_sel;
  logic acc_valid, cache_valid, dl_q, up_q, flush_q;
  logic push, pop, full, empty, rd_pend, ack_rd;
  logic [1:0] state;
  logic [EW-1:0] head;
  assign word = dio_a[ADDR_WIDTH-1:2];
  assign new_data = dio_dout & lane_mask(dio_sel);
  assign {head_adr, head_sel, head_dat} = head;
  // every push source retires the current accumulator
  assign push = acc_valid & (acc_be == 4'hF | flush_q | (dio_wr & word != acc_adr));
  assign pop = state == ST_WRITE & wb_ack;
  assign ack_rd = state == ST_READ & wb_ack;
  assign rd_pend = uploading & (~cache_valid | word != cache_adr);
  dio_word_fifo #(.W(EW), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din({acc_adr, acc_be, acc_data}), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_adr <= '0;
      acc_data <= '0;
      acc_be <= '0;
      dl_q <= 1'b0;
      up_q <= 1'b0;
      flush_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      up_q <= uploading;
      flush_q <= dl_q & ~downloading;
      if (dio_wr) begin
        acc_valid <= 1'b1;
        acc_adr <= word;
        acc_data <= (!acc_valid || push) ? new_data : acc_data | new_data;
        acc_be <= (!acc_valid || push) ? dio_sel : acc_be | dio_sel;
      end else if (push) acc_valid <= 1'b0;
      if (~dl_q & downloading) overflow <= 1'b0;
      else if (push & full & ~pop) overflow <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      rd_adr <= '0;
      cache_valid <= 1'b0;
      cache_adr <= '0;
      cache_data <= '0;
      dio_din <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (!empty) state <= ST_WRITE;
        else if (rd_pend) begin
          state <= ST_READ;
          rd_adr <= word;
        end
      end else if (wb_ack) state <= ST_IDLE;
      if (ack_rd) begin
        cache_data <= wb_dat_i;
        cache_adr <= rd_adr;
        cache_valid <= 1'b1;
      end else if ((uploading & ~up_q) | (pop & head_adr == cache_adr)) cache_valid <= 1'b0;
      dio_din <= cache_data[{dio_a[1:0], 3'b000} +: 8];
    end
  assign wb_cyc = state != ST_IDLE;
  assign wb_stb = wb_cyc;
  assign wb_we = state == ST_WRITE;
  assign wb_adr = wb_we ? head_adr : wb_cyc ? rd_adr : '0;
  assign wb_sel = wb_we ? head_sel : {4{wb_cyc}};
  assign wb_dat_o = wb_we ? head_dat : '0;
  assign busy = acc_valid | ~empty | wb_cyc;
endmodule
